// File: rtl/arb8_pkg.sv
// rtl/arb8_pkg.sv - shared widths and state encoding for the 8x16 bus arbiter
//   N_REQ  : number of requesters
//   DATA_W : width of one requester lane and of the output bus
//   SEL_W  : width of a requester index
//   arb_state_t : ST_IDLE (arbitrating), ST_GRANT (one requester owns the bus)
package arb8_pkg;
    localparam int N_REQ  = 8;
    localparam int DATA_W = 16;
    localparam int SEL_W  = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;
endpackage

// File: rtl/Mux8Way16.sv
// rtl/Mux8Way16.sv - 8-way 16-bit multiplexer (out = input chosen by sel)
//   a..h : 16-bit candidate inputs, index 0..7
//   sel  : 3-bit input index
//   out  : selected 16-bit value
module Mux8Way16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [15:0] e,
    input  logic [15:0] f,
    input  logic [15:0] g,
    input  logic [15:0] h,
    input  logic [2:0]  sel,
    output logic [15:0] out
);
    always_comb begin
        case (sel)
            3'd0:    out = a;
            3'd1:    out = b;
            3'd2:    out = c;
            3'd3:    out = d;
            3'd4:    out = e;
            3'd5:    out = f;
            3'd6:    out = g;
            default: out = h;
        endcase
    end
endmodule

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational round-robin picker over 8 request lines
//   req   : request vector
//   ptr   : index with highest priority; search order ptr, ptr+1, ... wrapping 7->0
//   found : at least one request is set
//   idx   : first set request in search order (ptr when found=0)
module rr_pick8
    import arb8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);
    always_comb begin : search
        logic [SEL_W-1:0] cand;
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            // SEL_W-bit addition wraps naturally from 7 back to 0
            cand = ptr + SEL_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/bus_arbiter8x16.sv
// rtl/bus_arbiter8x16.sv - round-robin arbiter sharing one 16-bit bus among 8 requesters
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   req        : per-requester beat pending
//   in_data    : requester i data at [16*i+15:16*i]
//   in_ready   : one-hot, beat from requester i accepted this cycle
//   out_data   : granted requester's data (0 while idle)
//   out_valid  : out_data carries a beat; out_ready accepts it
//   grant, sel : registered one-hot grant and index of the owner
//   busy       : 1 while a requester owns the bus
//   lock       : ARB_LOCK_EN only - while lock[sel]=1 the burst limit is ignored
// Parameters: BURST_MAX (1..255 beats per grant), RESET_PTR (0..7)
module bus_arbiter8x16
    import arb8_pkg::*;
#(
    parameter int BURST_MAX = 4,
    parameter int RESET_PTR = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] in_data,
    output logic [N_REQ-1:0]        in_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_REQ-1:0]        grant,
    output logic [SEL_W-1:0]        sel,
    output logic                    busy
`ifdef ARB_LOCK_EN
   ,input  logic [N_REQ-1:0]        lock
`endif
);
    localparam int               CNT_W     = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BURST_MAX - 1);
    localparam logic [SEL_W-1:0] RESET_SEL = SEL_W'(RESET_PTR);

    arb_state_t       state, state_nxt;
    logic [N_REQ-1:0] grant_nxt;
    logic [SEL_W-1:0] sel_nxt, ptr, ptr_nxt;
    logic [CNT_W-1:0] beat_cnt, cnt_nxt;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic [DATA_W-1:0] mux_out;
    logic             accept;
    logic             at_last;
    logic             locked;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    Mux8Way16 u_mux (
        .a   (in_data[0*DATA_W +: DATA_W]),
        .b   (in_data[1*DATA_W +: DATA_W]),
        .c   (in_data[2*DATA_W +: DATA_W]),
        .d   (in_data[3*DATA_W +: DATA_W]),
        .e   (in_data[4*DATA_W +: DATA_W]),
        .f   (in_data[5*DATA_W +: DATA_W]),
        .g   (in_data[6*DATA_W +: DATA_W]),
        .h   (in_data[7*DATA_W +: DATA_W]),
        .sel (sel),
        .out (mux_out)
    );

`ifdef ARB_LOCK_EN
    assign locked = lock[sel];
`else
    assign locked = 1'b0;
`endif

    assign at_last = (beat_cnt == CNT_LAST);
    assign busy    = (state == ST_GRANT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            grant    <= '0;
            sel      <= '0;
            ptr      <= RESET_SEL;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            sel      <= sel_nxt;
            ptr      <= ptr_nxt;
            beat_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        sel_nxt   = sel;
        ptr_nxt   = ptr;
        cnt_nxt   = beat_cnt;
        out_valid = 1'b0;
        out_data  = '0;
        in_ready  = '0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_nxt = ST_GRANT;
                    grant_nxt = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    sel_nxt   = pick_idx;
                    cnt_nxt   = '0;
                end
            end
            ST_GRANT: begin
                out_valid = req[sel];
                out_data  = mux_out;
                accept    = out_valid & out_ready;
                if (accept) begin
                    in_ready = grant;
                end
                // Release when the owner goes quiet or its burst budget is spent;
                // a locked owner keeps the bus and the counter parks at its last value.
                if (!req[sel] || (accept && at_last && !locked)) begin
                    state_nxt = ST_IDLE;
                    grant_nxt = '0;
                    ptr_nxt   = sel + SEL_W'(1);
                    cnt_nxt   = '0;
                end else if (accept && !at_last) begin
                    cnt_nxt = beat_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_bus_arbiter8x16.sv
// tb/tb_bus_arbiter8x16.sv - self-checking bench for bus_arbiter8x16 against a behavioural model
module tb_bus_arbiter8x16;
    localparam int BURST_MAX = 4;
    localparam int RESET_PTR = 0;
`ifdef ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   req;
    logic [127:0] in_data;
    logic [7:0]   in_ready;
    logic [15:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   grant;
    logic [2:0]   sel;
    logic         busy;
    logic [7:0]   lock;

    bus_arbiter8x16 #(.BURST_MAX(BURST_MAX), .RESET_PTR(RESET_PTR)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant     (grant),
        .sel       (sel),
        .busy      (busy)
`ifdef ARB_LOCK_EN
       ,.lock      (lock)
`endif
    );

    always #5 clk = ~clk;

    int n_checks, n_pass, n_fail;
    // reference model: owner index (-1 = nobody), priority pointer, beats in current burst
    int owner, mptr, beats;
    logic [7:0] acc_mask;
    int dut_seq[$];
    int dut_beats[8];
    logic prev_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lane(input int i);
        return in_data[16*i +: 16];
    endfunction

    task automatic refresh(input int i);
        in_data[16*i +: 16] = 16'($urandom);
    endtask

    task automatic clear_beats();
        for (int i = 0; i < 8; i++) dut_beats[i] = 0;
    endtask

    task automatic check_outputs();
        logic [7:0]  eg, eir;
        logic        ev;
        logic [15:0] ed;
        if (owner < 0) begin
            eg = 8'h00; ev = 1'b0; ed = 16'h0000; eir = 8'h00;
        end else begin
            eg  = 8'(1) << owner;
            ev  = req[owner];
            ed  = lane(owner);
            eir = (ev && out_ready) ? eg : 8'h00;
        end
        chk("grant", grant, eg);
        chk("out_valid", out_valid, ev);
        chk("out_data", out_data, ed);
        chk("in_ready", in_ready, eir);
        chk("busy", busy, owner >= 0);
        if (owner >= 0) chk("sel", sel, owner);
        if (busy && !prev_busy) dut_seq.push_back(int'(sel));
        prev_busy = busy;
        for (int i = 0; i < 8; i++) if (in_ready[i]) dut_beats[i]++;
    endtask

    task automatic model_edge();
        acc_mask = 8'h00;
        if (owner < 0) begin
            if (req != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    if (owner < 0 && req[(mptr + k) % 8]) begin
                        owner = (mptr + k) % 8;
                        beats = 0;
                    end
                end
            end
        end else if (!req[owner]) begin
            mptr  = (owner + 1) % 8;
            owner = -1;
        end else if (out_ready) begin
            acc_mask[owner] = 1'b1;
            beats++;
            if (beats >= BURST_MAX && !(LOCK_EN && lock[owner])) begin
                mptr  = (owner + 1) % 8;
                owner = -1;
            end
        end
    endtask

    task automatic cycle();
        #2;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < 8; i++) if (acc_mask[i]) refresh(i);
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        #1;
        chk("rst_grant", grant, 8'h00);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 8'h00);
        chk("rst_data", out_data, 16'h0000);
        chk("rst_sel", sel, 3'd0);
        owner = -1; mptr = RESET_PTR; beats = 0; prev_busy = 1'b0;
        #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int left;
        int saw;
        logic [15:0] cap;
        n_checks = 0; n_pass = 0; n_fail = 0;
        reset = 1'b1; req = 8'h00; out_ready = 1'b0; lock = 8'h00; in_data = '0;
        for (int i = 0; i < 8; i++) refresh(i);
        owner = -1; mptr = RESET_PTR; beats = 0; prev_busy = 1'b0;
        clear_beats();

        #3;
        chk("init_grant", grant, 8'h00);
        chk("init_valid", out_valid, 1'b0);
        chk("init_busy", busy, 1'b0);
        chk("init_data", out_data, 16'h0000);
        #4 reset = 1'b0;
        @(posedge clk); #1;

        // 1: reset in the middle of a burst
        req = 8'h02; out_ready = 1'b1;
        cycle(); cycle(); cycle();
        chk("t1_beats", dut_beats[1], 2);
        do_reset();
        cycle();
        chk("t1_regrant", grant, 8'h02);
        req = 8'h00;
        cycle(); cycle();

        // 2: single requester with six queued beats -> bursts of 4 and 2
        clear_beats(); dut_seq.delete();
        left = 6;
        for (int c = 0; c < 14; c++) begin
            req = (left > 0) ? 8'h04 : 8'h00;
            cycle();
            if (acc_mask[2]) left--;
        end
        chk("t2_beats", dut_beats[2], 6);
        chk("t2_grants", dut_seq.size(), 2);

        // 3: everyone requesting -> strict rotation starting after requester 2
        dut_seq.delete();
        req = 8'hFF;
        for (int c = 0; c < 48; c++) cycle();
        chk("t3_count", dut_seq.size() >= 9, 1'b1);
        for (int k = 0; k < 9 && k < dut_seq.size(); k++) chk("t3_order", dut_seq[k], (3 + k) % 8);
        req = 8'h00;
        cycle(); cycle();

        // 4: backpressure on requester 5
        req = 8'h20; out_ready = 1'b0;
        cycle();
        cap = lane(5);
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("t4_valid", out_valid, 1'b1);
            chk("t4_ready", in_ready, 8'h00);
            chk("t4_data", out_data, cap);
        end
        clear_beats();
        out_ready = 1'b1;
        cycle();
        chk("t4_beat", dut_beats[5], 1);
        req = 8'h00;
        cycle(); cycle();

        // 5: wrap from 6 to 7 then 0; requester 3 drops after two beats -> ptr=4
        req = 8'h40;
        cycle(); cycle();
        req = 8'h00;
        cycle();
        dut_seq.delete();
        req = 8'h81;
        for (int c = 0; c < 12; c++) cycle();
        chk("t5_count", dut_seq.size() >= 2, 1'b1);
        if (dut_seq.size() >= 2) begin
            chk("t5_first", dut_seq[0], 7);
            chk("t5_second", dut_seq[1], 0);
        end
        req = 8'h00;
        cycle(); cycle();
        left = 2;
        for (int c = 0; c < 6; c++) begin
            req = (left > 0) ? 8'h08 : 8'h00;
            cycle();
            if (acc_mask[3]) left--;
        end
        req = 8'h11;
        cycle();
        chk("t5_ptr4", sel, 3'd4);
        req = 8'h00;
        cycle(); cycle();

        // 6: lock on requester 0 (burst limit only honoured without the lock feature)
        clear_beats();
        lock = 8'h01; left = 10; saw = 0;
        for (int c = 0; c < 40 && saw == 0; c++) begin
            req = {6'b0, 1'b1, left > 0};
            cycle();
            if (acc_mask[0]) left--;
            if (grant == 8'h02) saw = 1;
        end
        chk("t6_wait", saw, 1);
        chk("t6_beats0", dut_beats[0], LOCK_EN ? 10 : 4);
        req = 8'h00; lock = 8'h00;
        cycle(); cycle();

        // random traffic against the model, with one reset in the middle
        for (int c = 0; c < 600; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    if (!req[i]) refresh(i);
                    req[i] = ~req[i];
                end
            end
            if (LOCK_EN && $urandom_range(0, 9) == 0) lock = 8'($urandom);
            cycle();
            if (c == 300) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
